// File: rtl/pmod_scan_tx_pkg.sv
// ----------------------------------------------------------------------------
// pmod_scan_tx_pkg
// Shared definitions for the PMOD scan-link transmitter: FSM state encoding,
// the all-anodes-off pattern and the digit count of the display board.
// ----------------------------------------------------------------------------
package pmod_scan_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_t;

    localparam logic [3:0] ANODES_OFF = 4'b1111;
    localparam int         NUM_DIGITS = 4;

endpackage : pmod_scan_tx_pkg

// File: rtl/pmod_scan_tx_prescaler.sv
// ----------------------------------------------------------------------------
// scan_prescaler
// Free-running divider for the scan link. Counts 0..DIV_MAX-1 while run=1 and
// flags the last count as a one-clk tick, then wraps to 0. Holds while run=0.
//
// Ports:
//   clk    system clock
//   rst    asynchronous active-low reset
//   run    count enable
//   clear  synchronous clear to 0 (wins over run)
//   count  current counter value
//   tick   high during the final count of each period (only while run=1)
// ----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int DIV_WIDTH = 17,
    parameter int DIV_MAX   = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic                 clear,
    output logic [DIV_WIDTH-1:0] count,
    output logic                 tick
);

    localparam logic [DIV_WIDTH-1:0] LAST = DIV_WIDTH'(DIV_MAX - 1);

    assign tick = run && (count == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule : scan_prescaler

// File: rtl/pmod_scan_tx.sv
// ----------------------------------------------------------------------------
// pmod_scan_tx
// Transmit end of the 5-wire PMOD scan link. Drives a divided scan clock on
// ja_out[4] and a rotating active-low anode strobe on ja_out[3:0]. Each digit
// is shown for two prescaler ticks (scan clock low, then high); anodes only
// change while the scan clock is low, so the receiver always samples stable
// anodes on its rising edge. Optional blanking ticks separate digits.
//
// Ports:
//   clk         system clock (100 MHz)
//   rst         asynchronous active-low reset
//   en          1 = scan, 0 = stop after the current digit
//   digit_mask  bit i enables digit i in the rotation
//   dim         (SCAN_DIM_EN only) anode on-time is (4-dim)/4 of SHOW
//   ja_out      [3:0] active-low anodes, [4] scan clock
//   digit_idx   digit currently shown; holds while blanking or idle
//   frame_done  one-clk pulse when the last enabled digit of a rotation ends
//   busy        high whenever not IDLE
//
// Build option: define SCAN_DIM_EN to add the dim input and PWM dimming.
// ----------------------------------------------------------------------------
module pmod_scan_tx
    import pmod_scan_tx_pkg::*;
#(
    parameter int DIV_WIDTH   = 17,
    parameter int DIV_MAX     = 100000,
    parameter int BLANK_TICKS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] digit_mask,
`ifdef SCAN_DIM_EN
    input  logic [1:0] dim,
`endif
    output logic [4:0] ja_out,
    output logic [1:0] digit_idx,
    output logic       frame_done,
    output logic       busy
);

    localparam int BW = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

    // Next enabled index strictly after cur, wrapping modulo 4. If only cur is
    // enabled it returns cur; if nothing is enabled it also returns cur, which
    // makes a vanished mask count as the end of the frame.
    function automatic logic [1:0] next_idx(input logic [1:0] cur,
                                            input logic [3:0] mask);
        logic [1:0] cand;
        next_idx = cur;
        // Walk from the farthest candidate to the nearest so the nearest wins.
        for (int k = NUM_DIGITS; k >= 1; k--) begin
            cand = cur + 2'(k);
            if (mask[cand]) next_idx = cand;
        end
    endfunction

    scan_state_t          state, state_n;
    logic [1:0]           digit_idx_n;
    logic                 sclk, sclk_n;
    logic [BW-1:0]        blank_cnt, blank_cnt_n;
    logic                 frame_done_n;
    logic                 pre_clear;
    logic                 pre_tick;
    logic [DIV_WIDTH-1:0] pre_count;
    logic                 anode_on;
    logic [3:0]           anodes;
    logic [1:0]           nxt;

    scan_prescaler #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_MAX   (DIV_MAX)
    ) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .run   (state != ST_IDLE),
        .clear (pre_clear),
        .count (pre_count),
        .tick  (pre_tick)
    );

`ifdef SCAN_DIM_EN
    logic [1:0] dim_q, dim_n;
    logic       second_half;
    logic [1:0] quarter;

    // Quarter of the SHOW window: scan-clock phase picks the tick, the
    // counter half picks the quarter within it.
    assign second_half = ({pre_count, 1'b0} >= (DIV_WIDTH + 1)'(DIV_MAX));
    assign quarter     = {sclk, second_half};
    assign anode_on    = ({1'b0, quarter} < (3'd4 - {1'b0, dim_q}));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) dim_q <= 2'd0;
        else      dim_q <= dim_n;
    end
`else
    logic unused_count;
    assign unused_count = ^pre_count;
    assign anode_on     = 1'b1;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            digit_idx  <= 2'd0;
            sclk       <= 1'b0;
            blank_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            digit_idx  <= digit_idx_n;
            sclk       <= sclk_n;
            blank_cnt  <= blank_cnt_n;
            frame_done <= frame_done_n;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_n      = state;
        digit_idx_n  = digit_idx;
        sclk_n       = sclk;
        blank_cnt_n  = blank_cnt;
        frame_done_n = 1'b0;
        pre_clear    = 1'b0;
        nxt          = next_idx(digit_idx, digit_mask);
`ifdef SCAN_DIM_EN
        dim_n        = dim_q;
`endif
        unique case (state)
            ST_IDLE: begin
                sclk_n = 1'b0;
                if (en && (digit_mask != 4'd0)) begin
                    state_n     = ST_SHOW;
                    // Searching after index 3 yields the lowest enabled index.
                    digit_idx_n = next_idx(2'd3, digit_mask);
                    pre_clear   = 1'b1;
`ifdef SCAN_DIM_EN
                    dim_n       = dim;
`endif
                end
            end

            ST_SHOW: begin
                if (pre_tick) begin
                    if (!sclk) begin
                        sclk_n = 1'b1;
                    end else begin
                        // Digit end: scan clock falls.
                        sclk_n       = 1'b0;
                        frame_done_n = (nxt <= digit_idx);
                        if (!en || (digit_mask == 4'd0)) begin
                            state_n = ST_IDLE;
                        end else if (BLANK_TICKS > 0) begin
                            state_n     = ST_BLANK;
                            blank_cnt_n = '0;
                        end else begin
                            digit_idx_n = nxt;
`ifdef SCAN_DIM_EN
                            dim_n       = dim;
`endif
                        end
                    end
                end
            end

            ST_BLANK: begin
                sclk_n = 1'b0;
                if (pre_tick) begin
                    if (int'(blank_cnt) == BLANK_TICKS - 1) begin
                        if (!en || (digit_mask == 4'd0)) begin
                            state_n = ST_IDLE;
                        end else begin
                            state_n     = ST_SHOW;
                            digit_idx_n = nxt;
`ifdef SCAN_DIM_EN
                            dim_n       = dim;
`endif
                        end
                    end else begin
                        blank_cnt_n = blank_cnt + 1'b1;
                    end
                end
            end

            default: begin
                state_n = ST_IDLE;
                sclk_n  = 1'b0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        anodes = ANODES_OFF;
        if ((state == ST_SHOW) && anode_on) anodes[digit_idx] = 1'b0;
        ja_out = {sclk && (state == ST_SHOW), anodes};
        busy   = (state != ST_IDLE);
    end

endmodule : pmod_scan_tx

// File: tb/tb_pmod_scan_tx.sv
// ----------------------------------------------------------------------------
// tb_pmod_scan_tx
// Directed bench for pmod_scan_tx with DIV_MAX=4. Instance a has one blanking
// tick, instance b has none. Expected values are hand-derived cycle tables;
// cycle n is sampled on the falling edge after rising edge n, with en raised
// at cycle 0.
// ----------------------------------------------------------------------------
module tb_pmod_scan_tx;

    typedef struct {
        int         scen;
        int         cyc;
        logic [4:0] ja;
        logic [1:0] idx;
        logic       fd;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       a_en = 1'b0, b_en = 1'b0;
    logic [3:0] a_mask = 4'd0, b_mask = 4'd0;
    logic [4:0] a_ja, b_ja;
    logic [1:0] a_idx, b_idx;
    logic       a_fd, b_fd, a_busy, b_busy;
`ifdef SCAN_DIM_EN
    logic [1:0] a_dim = 2'd0, b_dim = 2'd0;
`endif

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pmod_scan_tx #(.DIV_WIDTH(4), .DIV_MAX(4), .BLANK_TICKS(1)) u_dut_a (
        .clk(clk), .rst(rst), .en(a_en), .digit_mask(a_mask),
`ifdef SCAN_DIM_EN
        .dim(a_dim),
`endif
        .ja_out(a_ja), .digit_idx(a_idx), .frame_done(a_fd), .busy(a_busy)
    );

    pmod_scan_tx #(.DIV_WIDTH(4), .DIV_MAX(4), .BLANK_TICKS(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(b_en), .digit_mask(b_mask),
`ifdef SCAN_DIM_EN
        .dim(b_dim),
`endif
        .ja_out(b_ja), .digit_idx(b_idx), .frame_done(b_fd), .busy(b_busy)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic add(input int s, input int c, input logic [4:0] ja,
                       input logic [1:0] idx, input logic fd, input logic bsy);
        vec_t v;
        v.scen = s; v.cyc = c; v.ja = ja; v.idx = idx; v.fd = fd; v.busy = bsy;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_en = 1'b0; b_en = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst  = 1'b1;
    endtask

    task automatic check_rows(input int s, input int c);
        foreach (vecs[i]) begin
            if (vecs[i].scen == s && vecs[i].cyc == c) begin
                check($sformatf("s%0d_c%0d_ja", s, c),   32'(a_ja),   32'(vecs[i].ja));
                check($sformatf("s%0d_c%0d_idx", s, c),  32'(a_idx),  32'(vecs[i].idx));
                check($sformatf("s%0d_c%0d_fd", s, c),   32'(a_fd),   32'(vecs[i].fd));
                check($sformatf("s%0d_c%0d_busy", s, c), 32'(a_busy), 32'(vecs[i].busy));
            end
        end
    endtask

    // Runs one table scenario on instance a. Scenario 2 drops en mid-SHOW of
    // digit 2 (driven before edge 29).
    task automatic run_scen(input int s, input logic [3:0] mask, input int last,
                            output int fd_pulses, output int an3_low);
        fd_pulses = 0;
        an3_low   = 0;
        do_reset();
        a_mask = mask;
        check_rows(s, 0);
        a_en = 1'b1;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_rows(s, c);
            if (a_fd) fd_pulses++;
            if (!a_ja[3]) an3_low++;
            if (s == 2 && c == 28) a_en = 1'b0;
        end
    endtask

    initial begin
        int fd_n, an3_n;
        int e_an, e_fd, e_sc;

        // Default rotation, mask 1111.
        add(0,  0, 5'b01111, 2'd0, 1'b0, 1'b0);
        add(0,  1, 5'b01110, 2'd0, 1'b0, 1'b1);
        add(0,  4, 5'b01110, 2'd0, 1'b0, 1'b1);
        add(0,  5, 5'b11110, 2'd0, 1'b0, 1'b1);
        add(0,  8, 5'b11110, 2'd0, 1'b0, 1'b1);
        add(0,  9, 5'b01111, 2'd0, 1'b0, 1'b1);
        add(0, 12, 5'b01111, 2'd0, 1'b0, 1'b1);
        add(0, 13, 5'b01101, 2'd1, 1'b0, 1'b1);
        add(0, 17, 5'b11101, 2'd1, 1'b0, 1'b1);
        add(0, 21, 5'b01111, 2'd1, 1'b0, 1'b1);
        add(0, 25, 5'b01011, 2'd2, 1'b0, 1'b1);
        add(0, 37, 5'b00111, 2'd3, 1'b0, 1'b1);
        add(0, 41, 5'b10111, 2'd3, 1'b0, 1'b1);
        add(0, 45, 5'b01111, 2'd3, 1'b1, 1'b1);
        add(0, 46, 5'b01111, 2'd3, 1'b0, 1'b1);
        add(0, 49, 5'b01110, 2'd0, 1'b0, 1'b1);
        // Masked rotation, mask 1010.
        add(1,  1, 5'b01101, 2'd1, 1'b0, 1'b1);
        add(1,  9, 5'b01111, 2'd1, 1'b0, 1'b1);
        add(1, 13, 5'b00111, 2'd3, 1'b0, 1'b1);
        add(1, 17, 5'b10111, 2'd3, 1'b0, 1'b1);
        add(1, 21, 5'b01111, 2'd3, 1'b1, 1'b1);
        add(1, 25, 5'b01101, 2'd1, 1'b0, 1'b1);
        add(1, 33, 5'b01111, 2'd1, 1'b0, 1'b1);
        add(1, 37, 5'b00111, 2'd3, 1'b0, 1'b1);
        add(1, 45, 5'b01111, 2'd3, 1'b1, 1'b1);
        // Graceful stop during digit 2.
        add(2, 25, 5'b01011, 2'd2, 1'b0, 1'b1);
        add(2, 29, 5'b11011, 2'd2, 1'b0, 1'b1);
        add(2, 32, 5'b11011, 2'd2, 1'b0, 1'b1);
        add(2, 33, 5'b01111, 2'd2, 1'b0, 1'b0);
        add(2, 40, 5'b01111, 2'd2, 1'b0, 1'b0);
        add(2, 50, 5'b01111, 2'd2, 1'b0, 1'b0);

        run_scen(0, 4'b1111, 50, fd_n, an3_n);
        check("rot_fd_pulses", 32'(fd_n), 32'd1);
        run_scen(1, 4'b1010, 46, fd_n, an3_n);
        check("mask_fd_pulses", 32'(fd_n), 32'd2);
        run_scen(2, 4'b1111, 50, fd_n, an3_n);
        check("stop_no_digit3", 32'(an3_n), 32'd0);

        // No blanking, single digit: anode held, scan clock period 8,
        // frame_done every 8 clks.
        do_reset();
        b_mask = 4'b0001;
        b_en   = 1'b1;
        e_an = 0; e_fd = 0; e_sc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (b_ja[3:0] !== 4'b1110) e_an++;
            if (b_fd !== ((c >= 9) && (c % 8 == 1))) e_fd++;
            if (b_ja[4] !== (((c - 1) % 8) >= 4)) e_sc++;
        end
        check("nb_anode_errs", 32'(e_an), 32'd0);
        check("nb_fd_errs", 32'(e_fd), 32'd0);
        check("nb_sclk_errs", 32'(e_sc), 32'd0);
        check("nb_idx", 32'(b_idx), 32'd0);

        // Async reset while the scan clock is high.
        do_reset();
        a_mask = 4'b1111;
        a_en   = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("ar_pre_ja", 32'(a_ja), 32'b11110);
        #2 rst = 1'b0;
        #1;
        check("ar_ja", 32'(a_ja), 32'b01111);
        check("ar_busy", 32'(a_busy), 32'd0);
        check("ar_idx", 32'(a_idx), 32'd0);
        check("ar_fd", 32'(a_fd), 32'd0);
        @(negedge clk);
        a_en = 1'b0;
        rst  = 1'b1;
        repeat (10) @(negedge clk);
        check("ar_idle_ja", 32'(a_ja), 32'b01111);
        check("ar_idle_busy", 32'(a_busy), 32'd0);
        a_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("ar_restart_ja", 32'(a_ja), 32'b01110);

`ifdef SCAN_DIM_EN
        // dim=2: anode low for the first half of the 8-clk SHOW window.
        do_reset();
        a_mask = 4'b0001;
        a_dim  = 2'd2;
        a_en   = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("dim_c%0d", c), 32'(a_ja),
                  (c <= 4) ? 32'b01110 : 32'b11111);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pmod_scan_tx

// File: doc/pmod_scan_tx.md
Name: pmod_scan_tx

Overview:
- Transmit end of the 5-wire PMOD scan link (JA) used by the seven-segment display board.
- Generates the divided scan clock on ja_out[4] and the rotating active-low anode strobe on ja_out[3:0].
- The receiving board displays its own hex digits under this strobe.
- Sits on the matrix-multiplier board, driven by control logic through an enable/mask/frame handshake.

Parameters:
- DIV_WIDTH, 17, prescaler counter width.
- DIV_MAX, 100000, clk cycles per scan tick; legal range 2..2^DIV_WIDTH-1.
- BLANK_TICKS, 1, ticks of all-anodes-off between digits (ghost suppression); 0 means no blanking.

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  reset; asynchronous, active-low.
- en  input  1  level; 1 = scan, 0 = stop after the current digit.
- digit_mask  input  4  bit i = 1 enables digit i (an[i]) in the rotation.
- ja_out  output  5  [3:0] active-low anodes, [4] scan clock.
- digit_idx  output  2  index of the digit currently shown; holds last value while blanking or idle.
- frame_done  output  1  one-clk pulse when the last enabled digit of a rotation ends.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=0): ja_out=5'b01111, digit_idx=0, frame_done=0, busy=0, prescaler=0, state=IDLE.
- Prescaler:
  - Counts 0..DIV_MAX-1 while not IDLE; tick = (count==DIV_MAX-1), then wraps to 0.
  - Cleared on entry to SHOW from IDLE.
- States: IDLE, SHOW, BLANK.
- IDLE:
  - Anodes 1111, scan clock 0.
  - When en=1 and digit_mask!=0: next clk enter SHOW with the lowest enabled index. Anode low on that same edge; busy=1.
- SHOW:
  - Anode[digit_idx]=0, all others 1.
  - First tick: scan clock rises. Second tick: scan clock falls; this is the digit end.
  - Anodes only change while the scan clock is low, so the receiver sees stable anodes at every rising edge.
- Digit end:
  - Select the next enabled index above digit_idx, wrapping modulo 4.
  - frame_done pulses on the digit-end clk if the next index is <= the current one (wrap), or if exactly one digit is enabled.
  - If en=0, or digit_mask==0 (sampled at digit end): go to IDLE; frame_done still pulses if this was the last enabled digit.
  - Otherwise go to BLANK if BLANK_TICKS>0, else go directly to SHOW of the next digit.
- BLANK:
  - Anodes 1111, scan clock 0, for BLANK_TICKS ticks.
  - Then SHOW of the next index, recomputed from the digit_mask value at BLANK exit.
  - If the mask became 0, or en=0 at exit, go to IDLE.
- digit_mask changes never affect the digit currently in SHOW.
- en toggling inside SHOW is ignored until digit end.
- Reset mid-operation forces the reset values immediately; no partial pulse.

Optional Feature:
- SCAN_DIM_EN defined:
  - Adds port dim (input, 2 bits).
  - During SHOW, the anode is driven low only for the first (4-dim)/4 of the SHOW window, measured in prescaler quarters; dim=3 means 1/4 on-time.
  - dim=0 is full on; the scan clock is unaffected.
  - dim is sampled at SHOW entry.
- Undefined: no dim port; anode is low for the whole SHOW window.

Decomposition:
- Shared package: state encoding (IDLE/SHOW/BLANK), ANODES_OFF=4'b1111, NUM_DIGITS=4.
- One sub-module, scan_prescaler: counter with clear and tick output, parameterised by DIV_WIDTH and DIV_MAX.
- Next-index selection (masked rotate with wrap) stays as a function in the top.

Test Plan:
- Default rotation, DIV_MAX=4, BLANK_TICKS=1, mask=1111, en rises at cycle 0:
  - cycle 1: ja_out=01110.
  - cycle 5: ja_out[4]=1.
  - cycle 9: ja_out=01111.
  - cycle 13: ja_out=01101.
  - frame_done single pulse at the end of digit 3; sequence repeats.
- Masked rotation, mask=1010: anodes alternate 1101 -> 0111 -> 1101; digit_idx 1,3,1; frame_done pulses after every idx 3.
- Graceful stop: drop en mid-SHOW of digit 2 → digit 2 completes its full scan-clock period, then IDLE (ja_out=01111, busy=0); no digit 3 is shown.
- No blanking, BLANK_TICKS=0, mask=0001: anode 1110 held continuously; frame_done pulses once per 2 ticks (every 8 clks); scan clock period 8.
- Async reset in SHOW with scan clock high: rst=0 → ja_out=01111 immediately, without a clock edge; after release, stays IDLE until en=1.
- SCAN_DIM_EN with dim=2, DIV_MAX=4: anode low for 4 of the 8 SHOW clks, high for the remainder; scan clock edges unchanged.
